// File: rtl/meduram_pkg.sv
// meduram_pkg: shared types and helpers for the BRAM bank write arbiter.
// The INIT state is only used when MEDURAM_WRARB_INIT_EN is defined.
package meduram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(
    input int nb_req,
    input int nb_wragent,
    input int addr_width,
    input int ram_depth
  );
    return (nb_wragent >= 1) && (nb_wragent <= nb_req)
        && (ram_depth >= 1) && (ram_depth <= (2 ** addr_width));
  endfunction

endpackage

// File: rtl/meduram_rr_picker.sv
// meduram_rr_picker: combinational round-robin scan with address-conflict
// masking; k-th grant in scan order lands on port k.
module meduram_rr_picker
  import meduram_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int NB_WRAGENT = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int IDX_W      = 2
) (
  input  logic [NB_REQ-1:0]            i_valid,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [IDX_W-1:0]             i_ptr,
  output logic [NB_REQ-1:0]            o_grant,
  output logic [NB_WRAGENT-1:0]        o_port_vld,
  output logic [NB_WRAGENT*IDX_W-1:0]  o_port_idx,
  output logic [IDX_W-1:0]             o_next_ptr
);

  logic [NB_WRAGENT*ADDR_WIDTH-1:0] w_taken;
  logic [ADDR_WIDTH-1:0]            w_cur;
  logic                             w_hit;
  int                               w_n;
  int                               w_idx;

  always_comb begin
    o_grant    = '0;
    o_port_vld = '0;
    o_port_idx = '0;
    o_next_ptr = i_ptr;
    w_taken    = '0;
    w_cur      = '0;
    w_hit      = 1'b0;
    w_n        = 0;
    w_idx      = 0;
    for (int k = 0; k < NB_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NB_REQ) w_idx = w_idx - NB_REQ;
      w_cur = i_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_hit = 1'b0;
      // Same-address losers stay pending and do not consume a port.
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if (j < w_n && w_taken[j*ADDR_WIDTH +: ADDR_WIDTH] == w_cur)
          w_hit = 1'b1;
      end
      if (i_valid[w_idx] && !w_hit && w_n < NB_WRAGENT) begin
        o_grant[w_idx]                    = 1'b1;
        o_port_vld[w_n]                   = 1'b1;
        o_port_idx[w_n*IDX_W +: IDX_W]    = IDX_W'(w_idx);
        w_taken[w_n*ADDR_WIDTH +: ADDR_WIDTH] = w_cur;
        o_next_ptr = (w_idx == NB_REQ - 1) ? '0 : IDX_W'(w_idx + 1);
        w_n = w_n + 1;
      end
    end
  end

endmodule

// File: rtl/meduram_wr_arbiter.sv
// meduram_wr_arbiter: shares NB_WRAGENT BRAM write ports among NB_REQ requesters.
// Define MEDURAM_WRARB_INIT_EN to zero the whole RAM after reset.
module meduram_wr_arbiter
  import meduram_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int NB_WRAGENT = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NB_REQ-1:0]              req_valid,
  output logic [NB_REQ-1:0]              req_ready,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NB_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NB_WRAGENT-1:0]          wren,
  output logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  output logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  output logic                           init_busy
);

  localparam int IDX_W = idx_width(NB_REQ);

  if (!cfg_ok(NB_REQ, NB_WRAGENT, ADDR_WIDTH, RAM_DEPTH)) begin : g_cfg_err
    $error("meduram_wr_arbiter: need 1 <= NB_WRAGENT <= NB_REQ, RAM_DEPTH <= 2**ADDR_WIDTH");
  end

  logic [IDX_W-1:0]                w_next_ptr;
  logic [NB_REQ-1:0]               w_grant;
  logic [NB_WRAGENT-1:0]           w_port_vld;
  logic [NB_WRAGENT*IDX_W-1:0]     w_port_idx;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0] w_port_addr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] w_port_data;
  logic                            w_arb;

  logic [IDX_W-1:0]                r_ptr;
  logic [NB_WRAGENT-1:0]           r_wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0] r_wraddr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] r_wrdata;

  meduram_rr_picker #(
    .NB_REQ     (NB_REQ),
    .NB_WRAGENT (NB_WRAGENT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_picker (
    .i_valid    (req_valid),
    .i_addr     (req_addr),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_port_vld (w_port_vld),
    .o_port_idx (w_port_idx),
    .o_next_ptr (w_next_ptr)
  );

  always_comb begin
    w_port_addr = '0;
    w_port_data = '0;
    for (int k = 0; k < NB_WRAGENT; k++) begin
      w_port_addr[k*ADDR_WIDTH +: ADDR_WIDTH] =
        req_addr[int'(w_port_idx[k*IDX_W +: IDX_W])*ADDR_WIDTH +: ADDR_WIDTH];
      w_port_data[k*DATA_WIDTH +: DATA_WIDTH] =
        req_data[int'(w_port_idx[k*IDX_W +: IDX_W])*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef MEDURAM_WRARB_INIT_EN
  localparam int CNT_W    = ADDR_WIDTH + 2;
  localparam int LAST_CNT = (ceil_div(RAM_DEPTH, NB_WRAGENT) - 1) * NB_WRAGENT;

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  assign w_arb     = (r_state == ST_ARB);
  assign init_busy = (r_state == ST_INIT);
`else
  assign w_arb     = 1'b1;
  assign init_busy = 1'b0;
`endif

  assign req_ready = w_grant & {NB_REQ{w_arb & aresetn}};
  assign wren      = r_wren;
  assign wraddr    = r_wraddr;
  assign wrdata    = r_wrdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr    <= '0;
      r_wren   <= '0;
      r_wraddr <= '0;
      r_wrdata <= '0;
`ifdef MEDURAM_WRARB_INIT_EN
      r_state  <= ST_INIT;
      r_cnt    <= '0;
`endif
    end else if (w_arb) begin
      r_ptr <= w_next_ptr;
      // Idle ports keep their last addr/data to avoid needless toggling.
      for (int k = 0; k < NB_WRAGENT; k++) begin
        r_wren[k] <= w_port_vld[k];
        if (w_port_vld[k]) begin
          r_wraddr[k*ADDR_WIDTH +: ADDR_WIDTH] <=
            w_port_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          r_wrdata[k*DATA_WIDTH +: DATA_WIDTH] <=
            w_port_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
`ifdef MEDURAM_WRARB_INIT_EN
    else begin
      for (int k = 0; k < NB_WRAGENT; k++) begin
        if (r_cnt + CNT_W'(k) < CNT_W'(RAM_DEPTH)) begin
          r_wren[k] <= 1'b1;
          r_wraddr[k*ADDR_WIDTH +: ADDR_WIDTH] <= ADDR_WIDTH'(r_cnt + CNT_W'(k));
          r_wrdata[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end else begin
          r_wren[k] <= 1'b0;
        end
      end
      r_cnt <= r_cnt + CNT_W'(NB_WRAGENT);
      if (r_cnt == CNT_W'(LAST_CNT)) r_state <= ST_ARB;
    end
`endif
  end

endmodule

// File: tb/tb_meduram_wr_arbiter.sv
// tb_meduram_wr_arbiter: directed checks of grants, masking, packing and reset.
// Covers the init sequencer too when MEDURAM_WRARB_INIT_EN is defined.
module tb_meduram_wr_arbiter;

  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef MEDURAM_WRARB_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NW-1:0] wren;
  logic [NW*AW-1:0] wraddr;
  logic [NW*DW-1:0] wrdata;
  logic          init_busy;

  int total = 0;
  int bad   = 0;

  meduram_wr_arbiter #(
    .NB_REQ     (NR),
    .NB_WRAGENT (NW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (256),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wren      (wren),
    .wraddr    (wraddr),
    .wrdata    (wrdata),
    .init_busy (init_busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic all_valid();
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
  endtask

`ifdef MEDURAM_WRARB_INIT_EN
  task automatic run_init(input int n_cyc, input bit full);
    for (int n = 1; n <= n_cyc; n++) begin
      chk("init_busy", init_busy, 1'b1);
      chk("init_ready", req_ready, 4'b0000);
      cyc();
      chk("init_wren", wren, 2'b11);
      chk("init_addr", wraddr, {AW'(2 * n - 1), AW'(2 * n - 2)});
      chk("init_data", wrdata, 64'h0);
    end
    if (full) chk("init_done", init_busy, 1'b0);
  endtask
`endif

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (2) @(posedge aclk);
    #1;
    all_valid();
    settle();
    chk("rst_wren", wren, 2'b00);
    chk("rst_addr", wraddr, 16'h0);
    chk("rst_data", wrdata, 64'h0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", init_busy, BUSY_RST);
    aresetn = 1'b1;
    settle();

`ifdef MEDURAM_WRARB_INIT_EN
    run_init(50, 1'b0);
    aresetn = 1'b0;
    settle();
    chk("mid_init_wren", wren, 2'b00);
    chk("mid_init_addr", wraddr, 16'h0);
    chk("mid_init_busy", init_busy, 1'b1);
    cyc();
    aresetn = 1'b1;
    settle();
    run_init(128, 1'b1);
    settle();
`else
    chk("noinit_busy", init_busy, 1'b0);
`endif

    // all four valid, distinct addresses, pointer at 0
    chk("a0_ready", req_ready, 4'b0011);
    cyc();
    chk("a0_wren", wren, 2'b11);
    chk("a0_addr", wraddr, 16'h0201);
    chk("a0_data", wrdata, 64'h00000101_00000100);
    settle();
    chk("a1_ready", req_ready, 4'b1100);
    cyc();
    chk("a1_wren", wren, 2'b11);
    chk("a1_addr", wraddr, 16'h0403);
    chk("a1_data", wrdata, 64'h00000103_00000102);
    settle();
    chk("a2_ready", req_ready, 4'b0011);
    cyc();
    chk("a2_wren", wren, 2'b11);
    chk("a2_addr", wraddr, 16'h0201);

    // single requester 0 with pointer at 2: wraps, pointer becomes 1
    set_req(1, 1'b0, 8'h02, 32'h101);
    set_req(2, 1'b0, 8'h03, 32'h102);
    set_req(3, 1'b0, 8'h04, 32'h103);
    set_req(0, 1'b1, 8'h05, 32'h55);
    settle();
    chk("p_ready", req_ready, 4'b0001);
    cyc();
    chk("p_wren", wren, 2'b01);
    chk("p_addr_hold", wraddr, 16'h0205);
    chk("p_data_hold", wrdata, 64'h00000101_00000055);

    // same address on 1 and 2, pointer at 1
    set_req(0, 1'b0, 8'h05, 32'h55);
    set_req(1, 1'b1, 8'h10, 32'h11);
    set_req(2, 1'b1, 8'h10, 32'h22);
    settle();
    chk("b0_ready", req_ready, 4'b0010);
    cyc();
    chk("b0_wren", wren, 2'b01);
    chk("b0_addr", wraddr, 16'h0210);
    chk("b0_data", wrdata, 64'h00000101_00000011);
    set_req(1, 1'b0, 8'h10, 32'h11);
    settle();
    chk("b1_ready", req_ready, 4'b0100);
    cyc();
    chk("b1_wren", wren, 2'b01);
    chk("b1_data", wrdata, 64'h00000101_00000022);

    // single requester 3
    set_req(2, 1'b0, 8'h10, 32'h22);
    set_req(3, 1'b1, 8'hAA, 32'hDEADBEEF);
    settle();
    chk("c_ready", req_ready, 4'b1000);
    cyc();
    chk("c_wren", wren, 2'b01);
    chk("c_addr", wraddr, 16'h02AA);
    chk("c_data", wrdata, 64'h00000101_DEADBEEF);

    // idle cycle: nothing written, ports hold
    set_req(3, 1'b0, 8'hAA, 32'hDEADBEEF);
    settle();
    chk("idle_ready", req_ready, 4'b0000);
    cyc();
    chk("idle_wren", wren, 2'b00);
    chk("idle_addr", wraddr, 16'h02AA);

    // conflict masks requester 1, scan continues to 2
    set_req(0, 1'b1, 8'h33, 32'hA0);
    set_req(1, 1'b1, 8'h33, 32'hA1);
    set_req(2, 1'b1, 8'h44, 32'hA2);
    settle();
    chk("m0_ready", req_ready, 4'b0101);
    cyc();
    chk("m0_wren", wren, 2'b11);
    chk("m0_addr", wraddr, 16'h4433);
    chk("m0_data", wrdata, 64'h000000A2_000000A0);
    set_req(0, 1'b0, 8'h33, 32'hA0);
    set_req(2, 1'b0, 8'h44, 32'hA2);
    settle();
    chk("m1_ready", req_ready, 4'b0010);
    cyc();
    chk("m1_wren", wren, 2'b01);
    chk("m1_data", wrdata, 64'h000000A2_000000A1);

    // reset during arbitration with pointer at 2
    all_valid();
    settle();
    chk("r_pre_ready", req_ready, 4'b1100);
    aresetn = 1'b0;
    settle();
    chk("r_wren", wren, 2'b00);
    chk("r_addr", wraddr, 16'h0);
    chk("r_data", wrdata, 64'h0);
    chk("r_ready", req_ready, 4'b0000);
    cyc();
    aresetn = 1'b1;
    settle();
`ifdef MEDURAM_WRARB_INIT_EN
    run_init(128, 1'b1);
    settle();
`endif
    chk("r_post_ready", req_ready, 4'b0011);
    cyc();
    chk("r_post_wren", wren, 2'b11);
    chk("r_post_addr", wraddr, 16'h0201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meduram_wr_arbiter.md
# meduram_wr_arbiter

Write-side arbiter for the multi-port BRAM bank. It shares the NB_WRAGENT physical write ports among NB_REQ requesters using valid/ready handshakes, round-robin priority and same-cycle address-conflict masking. It drives the wren/wraddr/wrdata buses consumed by the bank and the memory-map accounter. An optional post-reset sequencer clears the whole RAM before the first grant.

## Interface
- NB_REQ, 4, number of write requesters; must be ≥ NB_WRAGENT.
- NB_WRAGENT, 2, number of physical write ports driven.
- ADDR_WIDTH, 8, address width in bits.
- RAM_DEPTH, 2**ADDR_WIDTH, number of words; used only by the init sequencer.
- DATA_WIDTH, 32, data width in bits.
- aclk  in  1  single clock.
- aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  NB_REQ  request valid, one bit per requester.
- req_ready  out  NB_REQ  request accepted this cycle.
- req_addr  in  NB_REQ*ADDR_WIDTH  packed request addresses; requester i at [i*ADDR_WIDTH+:ADDR_WIDTH].
- req_data  in  NB_REQ*DATA_WIDTH  packed request data.
- wren  out  NB_WRAGENT  write enable per port.
- wraddr  out  NB_WRAGENT*ADDR_WIDTH  packed port addresses.
- wrdata  out  NB_WRAGENT*DATA_WIDTH  packed port data.
- init_busy  out  1  high while the init sequencer owns the ports.

## Operation
- Transfer: a requester's write is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
  - The requester holds valid, addr and data stable until accepted.
  - req_valid must not depend on req_ready.
- Candidate scan: each cycle, requesters are scanned in circular order starting at pointer rr_ptr (0..NB_REQ-1).
  - The first NB_WRAGENT valid candidates are granted.
  - The k-th grant in scan order maps to port k.
- Conflict masking: a candidate whose address equals the address of a candidate already granted this cycle is skipped.
  - It stays pending and the scan continues.
  - As a result, two ports never write the same address in the same cycle.
- Pointer update: rr_ptr becomes (index of the last granted requester + 1) mod NB_REQ. With no grant, rr_ptr is unchanged.
- Port packing: ports beyond the number of grants get wren=0; their addr/data hold their previous values.
- FSM states, when MEDURAM_WRARB_INIT_EN is defined:
  - INIT → ARB once the clear counter reaches RAM_DEPTH.
  - ARB is terminal until reset.
- Reset values:
  - wren=0, wraddr=0, wrdata=0, req_ready=0, rr_ptr=0.
  - init_busy=1 if MEDURAM_WRARB_INIT_EN is defined, else 0.
  - clear counter = 0.
- Reset mid-operation: asserting aresetn low, including during INIT, returns everything to reset values. INIT restarts from address 0.

## Timing
- req_ready is combinational from req_valid, req_addr and rr_ptr, and is gated low during INIT.
- wren, wraddr and wrdata are registered: an accepted write appears on the port exactly 1 cycle after acceptance.
- Throughput: up to NB_WRAGENT accepted writes per cycle, sustained.
- Fairness: a continuously valid requester waits at most ceil(NB_REQ/NB_WRAGENT) cycles, provided it is not address-masked.
- INIT duration: ceil(RAM_DEPTH/NB_WRAGENT) cycles after reset release.
  - Port k writes address cnt+k with data 0, only where cnt+k < RAM_DEPTH.
  - cnt advances by NB_WRAGENT per cycle.
  - init_busy falls in the cycle after the last clear write is registered.
  - req_ready may assert in that same cycle.

## Configuration
- MEDURAM_WRARB_INIT_EN defined: the INIT state and clear counter are built; after reset, all RAM words are zeroed before any requester is granted.
- MEDURAM_WRARB_INIT_EN undefined: there is no INIT state; the arbiter starts in ARB, init_busy is tied to 0, and the counter logic is absent.

## Structure
- Shared package meduram_pkg holds:
  - the FSM state typedef (INIT, ARB);
  - a ceiling-division function for the init cycle count;
  - an elaboration check that NB_WRAGENT ≤ NB_REQ.
- One sub-module, meduram_rr_picker: purely combinational. It takes valid, addresses and rr_ptr, and returns the grant vector, the per-port requester index and the next pointer.
- The top level holds the FSM, pointer register, output registers and init counter.

## Test plan
- Reset with the macro defined, RAM_DEPTH=256, NB_WRAGENT=2 → init_busy high for 128 cycles, ports write addresses 0..255 with data 0, req_ready stays 0 throughout.
- All 4 requesters valid, distinct addresses, rr_ptr=0 → requesters 0 and 1 are granted on ports 0 and 1, then 2 and 3, then 0 and 1; wren=2'b11 every cycle, one cycle after each grant.
- Requesters 1 and 2 valid with the same address 0x10, rr_ptr=1 → only 1 is granted. Next cycle, rr_ptr=2 and requester 2 is granted to port 0 with wren=2'b01.
- A single requester (3) valid, addr=0xAA, data=0xDEADBEEF → req_ready[3]=1; the next cycle shows wren=2'b01, wraddr port0=0xAA, wrdata port0=0xDEADBEEF.
- aresetn asserted low at INIT cycle 50 → outputs return to reset values immediately; after release, clearing restarts at address 0 and lasts a full 128 cycles.
- Macro undefined → req_ready is valid from the first cycle after reset release and init_busy stays 0.
